// File: rtl/risc_pkg.sv
// ---------------------------------------------------------------------------
// risc_pkg
//   Shared types and constants for the RV32I run controller slice.
//   - run_state_e : run-controller state encoding (2-bit)
//   - RISC_XLEN   : default core result-bus width
//   - RISC_END_SIG: default end-of-test signature on the core result bus
// ---------------------------------------------------------------------------
package risc_pkg;

    localparam int RISC_XLEN = 32;

    localparam logic [31:0] RISC_END_SIG = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } run_state_e;

endpackage : risc_pkg

// File: rtl/risc_trace_buf.sv
// ---------------------------------------------------------------------------
// risc_trace_buf
//   Circular trace of the core result bus. While run is high, din is stored
//   whenever it differs from the last stored value (the first sample after
//   clear is always stored). The write pointer wraps so the oldest entry is
//   overwritten; cnt saturates at DEPTH. Reads are combinational and indexed
//   from the oldest entry; an index at or beyond cnt reads as zero.
//   Only instantiated when RUN_CTRL_TRACE_EN is defined.
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   clear        empties the buffer (takes priority over writes)
//   run          core is running; sampling enabled
//   din          core result bus
//   rd_idx       read index, 0 = oldest
//   rd_data      entry at rd_idx, or 0 if rd_idx >= cnt
//   cnt          number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module risc_trace_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            run,
    input  logic [XLEN-1:0] din,
    input  logic [AW-1:0]   rd_idx,
    output logic [XLEN-1:0] rd_data,
    output logic [AW:0]     cnt
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] last_q, last_d;
    logic            have_last_q, have_last_d;
    logic            wr_en;
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   rd_ptr;

    // Change filter: consecutive repeats of the same value are not stored.
    assign wr_en = run && !clear && (!have_last_q || (din != last_q));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        have_last_d = have_last_q;
        if (clear) begin
            wr_ptr_d    = '0;
            cnt_d       = '0;
            last_d      = '0;
            have_last_d = 1'b0;
        end else if (wr_en) begin
            // DEPTH is a power of two, so the pointer wraps naturally.
            wr_ptr_d    = wr_ptr_q + AW'(1);
            cnt_d       = (cnt_q == (AW+1)'(DEPTH)) ? cnt_q : cnt_q + (AW+1)'(1);
            last_d      = din;
            have_last_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            have_last_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
        end
    end

    // NOTE: the storage array is not reset; entries at or beyond cnt are never returned, so its contents are don't-care.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Until the buffer is full the oldest entry sits at slot 0; once full it
    // is the slot the next write would overwrite.
    assign oldest  = (cnt_q == (AW+1)'(DEPTH)) ? wr_ptr_q : '0;
    assign rd_ptr  = oldest + rd_idx;
    assign rd_data = ({1'b0, rd_idx} < cnt_q) ? mem_q[rd_ptr] : '0;
    assign cnt     = cnt_q;

endmodule : risc_trace_buf

// File: rtl/risc_run_ctrl.sv
// ---------------------------------------------------------------------------
// risc_run_ctrl
//   Run controller for the RV32I core. On start it holds the core in reset
//   for RST_CYCLES cycles, then runs it for at most MAX_CYCLES cycles while
//   watching core_out for END_SIG, and latches the verdict (pass / timeout)
//   together with the final core_out value and the run-cycle count.
//   The core stays parked in reset in IDLE and DONE.
// Configuration
//   RUN_CTRL_TRACE_EN : adds a TRACE_DEPTH-entry change-filtered trace of
//                       core_out and the trace_* ports.
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   start        1-cycle pulse; honoured only in IDLE or DONE
//   core_out     core result bus
//   core_rst     reset to the core (high except in RUN)
//   busy         high in RESET_HOLD and RUN
//   done         high in DONE
//   pass         END_SIG seen (valid with done)
//   timeout      budget exhausted (valid with done)
//   final_out    core_out sampled on the terminating run cycle
//   cycle_count  run cycles elapsed
//   trace_idx    trace read index, 0 = oldest      (RUN_CTRL_TRACE_EN)
//   trace_data   trace entry at trace_idx          (RUN_CTRL_TRACE_EN)
//   trace_cnt    valid trace entries, saturating   (RUN_CTRL_TRACE_EN)
// ---------------------------------------------------------------------------
module risc_run_ctrl
    import risc_pkg::*;
#(
    parameter int              XLEN       = RISC_XLEN,
    parameter int              RST_CYCLES = 2,
    parameter int              MAX_CYCLES = 20,
    parameter int              CNT_W      = 16,
    parameter logic [XLEN-1:0] END_SIG    = XLEN'(RISC_END_SIG)
`ifdef RUN_CTRL_TRACE_EN
   ,parameter int              TRACE_DEPTH = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  core_out,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [XLEN-1:0]  final_out,
    output logic [CNT_W-1:0] cycle_count
`ifdef RUN_CTRL_TRACE_EN
   ,input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN-1:0]                trace_data,
    output logic [$clog2(TRACE_DEPTH):0]   trace_cnt
`endif
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [XLEN-1:0]  final_out_q, final_out_d;
    logic             enter_hold;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        final_out_d   = final_out_q;
        enter_hold    = 1'b0;

        case (state_q)
            IDLE: begin
                enter_hold = start;
            end
            RESET_HOLD: begin
                if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                // The count includes the terminating cycle, so it freezes at
                // that cycle's value + 1.
                cycle_count_d = cycle_count_q + CNT_W'(1);
                // Signature is tested first so it wins a tie with the budget.
                if (core_out == END_SIG) begin
                    state_d     = DONE;
                    pass_d      = 1'b1;
                    final_out_d = core_out;
                end else if (cycle_count_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d     = DONE;
                    timeout_d   = 1'b1;
                    final_out_d = core_out;
                end
            end
            DONE: begin
                enter_hold = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new run clears the previous verdict on the same edge it starts.
        if (enter_hold) begin
            state_d       = RESET_HOLD;
            hold_cnt_d    = '0;
            cycle_count_d = '0;
            pass_d        = 1'b0;
            timeout_d     = 1'b0;
            final_out_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            final_out_q   <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            final_out_q   <= final_out_d;
        end
    end

    // Decoded from the state register, so rst parks the core immediately.
    assign core_rst    = (state_q != RUN);
    assign busy        = (state_q == RESET_HOLD) || (state_q == RUN);
    assign done        = (state_q == DONE);
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign final_out   = final_out_q;
    assign cycle_count = cycle_count_q;

`ifdef RUN_CTRL_TRACE_EN
    risc_trace_buf #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_buf (
        .clk     (clk),
        .rst     (rst),
        .clear   (enter_hold),
        .run     (state_q == RUN),
        .din     (core_out),
        .rd_idx  (trace_idx),
        .rd_data (trace_data),
        .cnt     (trace_cnt)
    );
`endif

endmodule : risc_run_ctrl

// File: tb/tb_risc_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_risc_run_ctrl
//   Scoreboard bench for risc_run_ctrl (default parameters). Each run pushes
//   the verdict predicted from the core_out sequence it is about to drive;
//   the entry is popped and compared when done rises.
// ---------------------------------------------------------------------------
module tb_risc_run_ctrl;

    localparam int          XLEN       = 32;
    localparam int          RST_CYCLES = 2;
    localparam int          MAX_CYCLES = 20;
    localparam int          CNT_W      = 16;
    localparam logic [31:0] END_SIG    = 32'h0000_0001;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [31:0] final_out;
        int          cc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [XLEN-1:0]  core_out;
    logic             core_rst;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [XLEN-1:0]  final_out;
    logic [CNT_W-1:0] cycle_count;
`ifdef RUN_CTRL_TRACE_EN
    logic [2:0]       trace_idx;
    logic [XLEN-1:0]  trace_data;
    logic [3:0]       trace_cnt;
`endif

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    risc_run_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .core_out    (core_out),
        .core_rst    (core_rst),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .final_out   (final_out),
        .cycle_count (cycle_count)
`ifdef RUN_CTRL_TRACE_EN
       ,.trace_idx   (trace_idx),
        .trace_data  (trace_data),
        .trace_cnt   (trace_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // core_out value driven on 0-based run cycle k for each scenario.
    function automatic logic [31:0] val_of(input int mode, input int k);
        case (mode)
            0:       return (k == 5)  ? END_SIG : 32'h100 + k;   // pass on run cycle 5
            1:       return 32'hDEAD_BEEF;                        // never ends
            2:       return (k == 19) ? END_SIG : 32'h200 + k;   // signature on last budget cycle
            default: return (k <= 1) ? 32'h101 : ((k <= 11) ? 32'h100 + k : 32'h10B);
        endcase
    endfunction

    function automatic exp_t model(input int mode);
        exp_t e;
        for (int k = 0; k < MAX_CYCLES; k++) begin
            if (val_of(mode, k) == END_SIG) begin
                e.pass = 1'b1; e.timeout = 1'b0; e.final_out = END_SIG; e.cc = k + 1;
                return e;
            end
        end
        e.pass = 1'b0; e.timeout = 1'b1; e.final_out = val_of(mode, MAX_CYCLES - 1); e.cc = MAX_CYCLES;
        return e;
    endfunction

    // abort_at >= 0 pulses rst on that run cycle; mid_start pulses start on run cycle 3.
    task automatic do_run(input int mode, input int abort_at, input bit mid_start);
        exp_t e;
        int   hold;
        int   k;
        sb.push_back(model(mode));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("clr_pass", pass, 0);
        check("clr_timeout", timeout, 0);
        check("clr_final_out", final_out, 0);
        check("clr_cycle_count", cycle_count, 0);
        check("hold_busy", busy, 1);
        hold = 0;
        while (core_rst && hold < 10) begin
            hold++;
            @(negedge clk);
        end
        check("hold_len", hold, RST_CYCLES);
        check("run_cc0", cycle_count, 0);
        k = 0;
        while (!done && k < 100) begin
            core_out = val_of(mode, k);
            start    = mid_start && (k == 3);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_core_rst", core_rst, 1);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_cycle_count", cycle_count, 0);
                @(negedge clk);
                rst      = 1'b0;
                start    = 1'b0;
                core_out = '0;
                void'(sb.pop_back());
                @(negedge clk);
                check("idle_core_rst", core_rst, 1);
                check("idle_pass", pass, 0);
                check("idle_timeout", timeout, 0);
                return;
            end
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", done, 1);
        e = sb.pop_front();
        check("run_len", k, e.cc);
        check("pass", pass, e.pass);
        check("timeout", timeout, e.timeout);
        check("final_out", final_out, e.final_out);
        check("cycle_count", cycle_count, e.cc);
        check("done_core_rst", core_rst, 1);
        check("done_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        core_out = '0;
`ifdef RUN_CTRL_TRACE_EN
        trace_idx = '0;
`endif
        #12;
        check("rst_core_rst", core_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_final_out", final_out, 0);
        check("rst_cycle_count", cycle_count, 0);
`ifdef RUN_CTRL_TRACE_EN
        check("rst_trace_cnt", trace_cnt, 0);
`endif
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("idle_parked", core_rst, 1);

        do_run(0, -1, 1'b0);   // pass on run cycle 5
        do_run(1, -1, 1'b1);   // timeout, start pulsed mid-run, restarted from DONE
        do_run(2, -1, 1'b0);   // signature and budget coincide
        do_run(1, 7, 1'b0);    // rst pulsed on run cycle 7
        do_run(0, -1, 1'b0);   // fresh run from IDLE after abort

`ifdef RUN_CTRL_TRACE_EN
        do_run(3, -1, 1'b0);
        check("trace_cnt", trace_cnt, 8);
        trace_idx = 3'd0; #1;
        check("trace_idx0", trace_data, 32'h104);
        trace_idx = 3'd3; #1;
        check("trace_idx3", trace_data, 32'h107);
        trace_idx = 3'd7; #1;
        check("trace_idx7", trace_data, 32'h10B);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_risc_run_ctrl
